pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter INSTR_W, default 16, instruction width; SHALL be >= 16; opcode = instr[INSTR_W-1 -: 3], cond = instr[INSTR_W-4 -: 2], func = instr[2:0].
REQ-002 Parameter DEPTH, default 16, maximum call nesting; DEPTH_W = clog2(DEPTH+1) SHALL be derived locally.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 instr_in  input  INSTR_W  fetched instruction; instr_valid  input  1  instr_in valid; instr_ready  output  1  word accepted on valid&ready edge.
REQ-006 hold  input  1  freeze both stages; z_flag  input  1  zero flag for stage-2 resolution.
REQ-007 alu_en, rr1_en, rr2_en, mov_en, datar_en, sp_dec  output  1 each  stage-1 enables.
REQ-008 regw_en, dataw_en, pc_load_en, sp_inc, spw_en, flush  output  1 each  stage-2 enables.
REQ-009 halted  output  1  HALT state; stack_err  output  1  sticky stack fault; depth  output  DEPTH_W  current call depth.

Function
REQ-010 Decode: op 000 ALU; op 001 func 0xx ALU, 100 MOV, 101 with cond 00 SP load, 01 RETZ, 10 RETNZ, 11 HLT; 010 load; 011 store; 100 JZ; 101 JNZ; 110 CZ; 111 CNZ.
REQ-011 Accepted word SHALL enter s1 (valid bit) at the edge; s1 SHALL move to s2 on the next edge unless hold, HALT or flush.
REQ-012 Stage-1 outputs SHALL be combinational from valid s1, gated by ~hold & ~flush & ~halted: alu_en=ALU; rr1_en=ALU|store; rr2_en=ALU|MOV; mov_en=MOV; datar_en=load|RETZ|RETNZ; sp_dec=CZ|CNZ.
REQ-013 Stage-2 taken terms: jt=(JZ&z)|(JNZ&~z); ct=(CZ&z)|(CNZ&~z); rt=(RETZ&z)|(RETNZ&~z).
REQ-014 Stage-2 outputs (valid s2, gated by ~hold & ~halted): regw_en=ALU|MOV|load; dataw_en=store|ct; pc_load_en=jt|ct|rt; spw_en=ct; sp_inc=rt|((CZ|CNZ)&~ct).
REQ-015 flush SHALL equal pc_load_en | (valid s2 HLT); s1 valid SHALL clear at that edge; instr_ready = ~rst & ~hold & ~halted & ~flush.
REQ-016 Latency: stage-1 outputs one cycle after acceptance, stage-2 outputs two cycles after, absent hold.
REQ-017 FSM states RUN, HOLD, HALT: RUN->HOLD on hold; HOLD->RUN when hold falls; RUN->HALT at edge with valid s2 HLT and ~hold; HALT exits only on rst.
REQ-018 In HOLD, s1, s2, depth SHALL not change; all enables 0; a simultaneous taken branch SHALL be resolved after hold falls, using z_flag at that time.
REQ-019 In HALT, halted=1, all enables 0, no new words accepted.
REQ-020 depth SHALL increment on an edge with ct and decrement on an edge with rt.

Reset
REQ-021 rst SHALL asynchronously clear s1/s2 valid, depth=0, stack_err=0, state RUN; every output 0 while rst high; instr_ready=1 first cycle after release.
REQ-022 rst mid-operation SHALL discard in-flight instructions without emitting any enable.

Configuration
REQ-023 Macro PIPE_CTRL_STACK_CHK_EN defined: ct at depth==DEPTH or rt at depth==0 SHALL be treated not taken (pc_load_en, spw_en, dataw_en from call 0; sp_inc=1 for the refused call to undo sp_dec; no flush) and set stack_err until reset.
REQ-024 Macro undefined: depth SHALL wrap modulo 2^DEPTH_W; stack_err tied 0.

Structure
REQ-025 Package pipe_ctrl_pkg SHALL hold opcode, func and cond constants and the state enum.
REQ-026 Combinational sub-module ctrl_decode SHALL decode one word into class flags, instantiated for s1 and s2.

Verification
REQ-027 ALU 16'h0000 accepted cycle 0 -> alu_en,rr1_en,rr2_en cycle 1; regw_en cycle 2.
REQ-028 JZ 16'h8000 then 16'h4000, z_flag=1 -> pc_load_en=1, flush=1 cycle 2; load squashed, no datar_en/regw_en from it.
REQ-029 CNZ 16'hE000 with z_flag=1 -> sp_dec cycle 1; cycle 2 sp_inc=1, pc_load_en=0, depth stays 0.
REQ-030 hold=1 during cycle 2 of JZ, z=1 -> all enables 0, instr_ready 0; hold released -> pc_load_en next cycle.
REQ-031 With PIPE_CTRL_STACK_CHK_EN, DEPTH=2: three CZ 16'hC000, z=1 -> depth 2, third refused, stack_err=1; RETZ 16'h2805 at depth 0 -> refused.
REQ-032 HLT 16'h3805 -> halted=1 cycle 2, instr_ready 0 thereafter; rst pulse -> halted 0, depth 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode/func/cond encodings, decoded class flags and controller state for pipe_ctrl.
package pipe_ctrl_pkg;

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_SYS   = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_JZ    = 3'b100;
    localparam logic [2:0] OP_JNZ   = 3'b101;
    localparam logic [2:0] OP_CZ    = 3'b110;
    localparam logic [2:0] OP_CNZ   = 3'b111;

    localparam logic [2:0] FN_MOV = 3'b100;
    localparam logic [2:0] FN_CTL = 3'b101;

    localparam logic [1:0] CD_SPLD  = 2'b00;
    localparam logic [1:0] CD_RETZ  = 2'b01;
    localparam logic [1:0] CD_RETNZ = 2'b10;
    localparam logic [1:0] CD_HLT   = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HOLD = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    typedef struct packed {
        logic alu;
        logic mov;
        logic spld;
        logic retz;
        logic retnz;
        logic hlt;
        logic load;
        logic store;
        logic jz;
        logic jnz;
        logic cz;
        logic cnz;
    } cls_t;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// ctrl_decode: purely combinational decode of one instruction word into class flags.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic [INSTR_W-1:0] instr_i,
    output cls_t               cls_o
);

    logic [2:0] op;
    logic [1:0] cond;
    logic [2:0] func;
    logic       unused_mid;

    assign op         = instr_i[INSTR_W-1 -: 3];
    assign cond       = instr_i[INSTR_W-4 -: 2];
    assign func       = instr_i[2:0];
    assign unused_mid = ^instr_i[INSTR_W-6:3];

    always_comb begin
        cls_o = '0;
        case (op)
            OP_ALU:   cls_o.alu   = 1'b1;
            OP_SYS: begin
                // func 0xx is an ALU form; 11x is an unused encoding
                if (!func[2]) begin
                    cls_o.alu = 1'b1;
                end else if (func == FN_MOV) begin
                    cls_o.mov = 1'b1;
                end else if (func == FN_CTL) begin
                    case (cond)
                        CD_SPLD:  cls_o.spld  = 1'b1;
                        CD_RETZ:  cls_o.retz  = 1'b1;
                        CD_RETNZ: cls_o.retnz = 1'b1;
                        CD_HLT:   cls_o.hlt   = 1'b1;
                    endcase
                end
            end
            OP_LOAD:  cls_o.load  = 1'b1;
            OP_STORE: cls_o.store = 1'b1;
            OP_JZ:    cls_o.jz    = 1'b1;
            OP_JNZ:   cls_o.jnz   = 1'b1;
            OP_CZ:    cls_o.cz    = 1'b1;
            OP_CNZ:   cls_o.cnz   = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: two-stage pipeline control with hold/halt FSM and call-depth tracking.
// Define PIPE_CTRL_STACK_CHK_EN to refuse calls/returns that would overflow/underflow depth.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INSTR_W-1:0]         instr_in,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic                       hold,
    input  logic                       z_flag,
    output logic                       alu_en,
    output logic                       rr1_en,
    output logic                       rr2_en,
    output logic                       mov_en,
    output logic                       datar_en,
    output logic                       sp_dec,
    output logic                       regw_en,
    output logic                       dataw_en,
    output logic                       pc_load_en,
    output logic                       sp_inc,
    output logic                       spw_en,
    output logic                       flush,
    output logic                       halted,
    output logic                       stack_err,
    output logic [$clog2(DEPTH+1)-1:0] depth
);

    localparam int DEPTH_W = $clog2(DEPTH + 1);

    state_e               state_q, state_d;
    logic                 s1v_q, s1v_d, s2v_q, s2v_d;
    logic [INSTR_W-1:0]   s1_instr_q, s2_instr_q;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 stack_err_q, stack_err_d;
    cls_t                 c1, c2;
    logic                 unused_cls;

    logic halt_q, adv, act1, act2, accept, halt_req;
    logic jt, ct_raw, rt_raw, ct_ref, rt_ref, ct, rt;

    ctrl_decode #(.INSTR_W(INSTR_W)) u_dec_s1 (.instr_i(s1_instr_q), .cls_o(c1));
    ctrl_decode #(.INSTR_W(INSTR_W)) u_dec_s2 (.instr_i(s2_instr_q), .cls_o(c2));

    assign unused_cls = ^{c1, c2};

    assign halt_q = (state_q == ST_HALT);
    assign adv    = ~hold & ~halt_q;
    assign act2   = s2v_q & adv;

    // Stage 2: branch/call/return resolution against the live zero flag
    assign jt     = (c2.jz & z_flag)   | (c2.jnz & ~z_flag);
    assign ct_raw = (c2.cz & z_flag)   | (c2.cnz & ~z_flag);
    assign rt_raw = (c2.retz & z_flag) | (c2.retnz & ~z_flag);

`ifdef PIPE_CTRL_STACK_CHK_EN
    assign ct_ref = ct_raw & (depth_q == DEPTH_W'(DEPTH));
    assign rt_ref = rt_raw & (depth_q == '0);
`else
    assign ct_ref = 1'b0;
    assign rt_ref = 1'b0;
`endif

    assign ct = ct_raw & ~ct_ref;
    assign rt = rt_raw & ~rt_ref;

    assign regw_en    = act2 & (c2.alu | c2.mov | c2.load);
    assign dataw_en   = act2 & (c2.store | ct);
    assign pc_load_en = act2 & (jt | ct | rt);
    assign spw_en     = act2 & ct;
    // A not-taken or refused call still pops the slot that stage 1 pre-decremented
    assign sp_inc     = act2 & (rt | ((c2.cz | c2.cnz) & ~ct));
    assign halt_req   = act2 & c2.hlt;
    assign flush      = pc_load_en | halt_req;

    // Stage 1: operand/read enables, suppressed by anything that squashes or freezes s1
    assign act1     = s1v_q & adv & ~flush;
    assign alu_en   = act1 & c1.alu;
    assign rr1_en   = act1 & (c1.alu | c1.store);
    assign rr2_en   = act1 & (c1.alu | c1.mov);
    assign mov_en   = act1 & c1.mov;
    assign datar_en = act1 & (c1.load | c1.retz | c1.retnz);
    assign sp_dec   = act1 & (c1.cz | c1.cnz);

    assign instr_ready = ~rst & adv & ~flush;
    assign accept      = instr_valid & instr_ready;
    assign halted      = halt_q | halt_req;
    assign stack_err   = stack_err_q;
    assign depth       = depth_q;

    always_comb begin
        state_d     = state_q;
        s1v_d       = s1v_q;
        s2v_d       = s2v_q;
        depth_d     = depth_q;
        stack_err_d = stack_err_q | (act2 & (ct_ref | rt_ref));
        case (state_q)
            ST_HALT: state_d = ST_HALT;
            default: begin
                if (halt_req)  state_d = ST_HALT;
                else if (hold) state_d = ST_HOLD;
                else           state_d = ST_RUN;
            end
        endcase
        if (adv) begin
            s1v_d = accept;
            s2v_d = s1v_q & ~flush;
        end
        if (act2 & ct)      depth_d = depth_q + DEPTH_W'(1);
        else if (act2 & rt) depth_d = depth_q - DEPTH_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            s1v_q       <= 1'b0;
            s2v_q       <= 1'b0;
            depth_q     <= '0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1v_q       <= s1v_d;
            s2v_q       <= s2v_d;
            depth_q     <= depth_d;
            stack_err_q <= stack_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) s1_instr_q <= instr_in;
        if (adv)    s2_instr_q <= s1_instr_q;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (DEPTH=2); expectations follow PIPE_CTRL_STACK_CHK_EN when defined.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_in;
    logic        instr_valid, instr_ready, hold, z_flag;
    logic        alu_en, rr1_en, rr2_en, mov_en, datar_en, sp_dec;
    logic        regw_en, dataw_en, pc_load_en, sp_inc, spw_en, flush;
    logic        halted, stack_err;
    logic [1:0]  depth;
    logic [5:0]  s1en, s2en;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.INSTR_W(16), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .hold(hold), .z_flag(z_flag),
        .alu_en(alu_en), .rr1_en(rr1_en), .rr2_en(rr2_en), .mov_en(mov_en),
        .datar_en(datar_en), .sp_dec(sp_dec), .regw_en(regw_en), .dataw_en(dataw_en),
        .pc_load_en(pc_load_en), .sp_inc(sp_inc), .spw_en(spw_en), .flush(flush),
        .halted(halted), .stack_err(stack_err), .depth(depth)
    );

    // {alu,rr1,rr2,mov,datar,sp_dec} and {regw,dataw,pc_load,sp_inc,spw,flush}
    assign s1en = {alu_en, rr1_en, rr2_en, mov_en, datar_en, sp_dec};
    assign s2en = {regw_en, dataw_en, pc_load_en, sp_inc, spw_en, flush};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one word alone; check stage-1 one cycle later, stage-2 two cycles later.
    task automatic run_word(input logic [15:0] w, input logic [5:0] e1, input logic [5:0] e2,
                            input string tag);
        instr_in    = w;
        instr_valid = 1'b1;
        @(negedge clk); check({tag, "/rdy"}, 32'(instr_ready), 32'd1);
        @(posedge clk); #1 instr_valid = 1'b0;
        @(negedge clk); check({tag, "/s1"}, 32'(s1en), 32'(e1));
        @(posedge clk); #1;
        @(negedge clk); check({tag, "/s2"}, 32'(s2en), 32'(e2));
        @(posedge clk); #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; instr_in = '0; instr_valid = 1'b0; hold = 1'b0; z_flag = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rst/s1", 32'(s1en), 32'd0);
        check("rst/s2", 32'(s2en), 32'd0);
        check("rst/rdy", 32'(instr_ready), 32'd0);
        check("rst/halted", 32'(halted), 32'd0);
        check("rst/depth", 32'(depth), 32'd0);
        check("rst/serr", 32'(stack_err), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); check("rel/rdy", 32'(instr_ready), 32'd1);
        @(posedge clk); #1;

        // Plain classes
        run_word(16'h0000, 6'b111000, 6'b100000, "alu");
        run_word(16'h2004, 6'b001100, 6'b100000, "mov");
        run_word(16'h4000, 6'b000010, 6'b100000, "load");
        run_word(16'h6000, 6'b010000, 6'b010000, "store");

        // Taken JZ squashes the load behind it
        z_flag = 1'b1; instr_in = 16'h8000; instr_valid = 1'b1;
        @(posedge clk); #1 instr_in = 16'h4000;
        @(negedge clk); check("jz/s1", 32'(s1en), 32'd0);
        check("jz/rdy1", 32'(instr_ready), 32'd1);
        @(posedge clk); #1 instr_valid = 1'b0;
        @(negedge clk); check("jz/s2", 32'(s2en), 32'(6'b001001));
        check("jz/squash_s1", 32'(s1en), 32'd0);
        check("jz/rdy2", 32'(instr_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); check("jz/after_s1", 32'(s1en), 32'd0);
        check("jz/after_s2", 32'(s2en), 32'd0);

        // CNZ with z=1: not taken, stack pointer restored
        @(posedge clk); #1;
        run_word(16'hE000, 6'b000001, 6'b000100, "cnz");
        check("cnz/depth", 32'(depth), 32'd0);

        // Hold over stage 2 of a JZ; resolve with z at release
        instr_in = 16'h8000; instr_valid = 1'b1; z_flag = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0;
        @(negedge clk); check("hold/s1", 32'(s1en), 32'd0);
        @(posedge clk); #1 hold = 1'b1; z_flag = 1'b0;
        @(negedge clk); check("hold/s2", 32'(s2en), 32'd0);
        check("hold/rdy", 32'(instr_ready), 32'd0);
        @(posedge clk); #1 z_flag = 1'b1;
        @(negedge clk); check("hold2/s2", 32'(s2en), 32'd0);
        @(posedge clk); #1 hold = 1'b0;
        @(negedge clk); check("hold/release", 32'(s2en), 32'(6'b001001));
        @(posedge clk); #1;
        @(negedge clk); check("hold/after", 32'(s2en), 32'd0);
        @(posedge clk); #1;

        // Calls up to and past DEPTH=2, then a return
        run_word(16'hC000, 6'b000001, 6'b011011, "cz1");
        check("cz1/depth", 32'(depth), 32'd1);
        run_word(16'hC000, 6'b000001, 6'b011011, "cz2");
        check("cz2/depth", 32'(depth), 32'd2);
        check("cz2/serr", 32'(stack_err), 32'd0);
`ifdef PIPE_CTRL_STACK_CHK_EN
        run_word(16'hC000, 6'b000001, 6'b000100, "cz3");
        check("cz3/depth", 32'(depth), 32'd2);
        check("cz3/serr", 32'(stack_err), 32'd1);
        run_word(16'h2805, 6'b000010, 6'b001101, "ret1");
        check("ret1/depth", 32'(depth), 32'd1);
`else
        run_word(16'hC000, 6'b000001, 6'b011011, "cz3");
        check("cz3/depth", 32'(depth), 32'd3);
        check("cz3/serr", 32'(stack_err), 32'd0);
        run_word(16'h2805, 6'b000010, 6'b001101, "ret1");
        check("ret1/depth", 32'(depth), 32'd2);
`endif
        pulse_rst();
        @(negedge clk); check("rst2/depth", 32'(depth), 32'd0);
        check("rst2/serr", 32'(stack_err), 32'd0);
        @(posedge clk); #1;

        // Return at depth 0
`ifdef PIPE_CTRL_STACK_CHK_EN
        run_word(16'h2805, 6'b000010, 6'b000000, "ret0");
        check("ret0/depth", 32'(depth), 32'd0);
        check("ret0/serr", 32'(stack_err), 32'd1);
`else
        run_word(16'h2805, 6'b000010, 6'b001101, "ret0");
        check("ret0/depth", 32'(depth), 32'd3);
        check("ret0/serr", 32'(stack_err), 32'd0);
`endif

        // Reset mid-flight discards the ALU word
        instr_in = 16'h0000; instr_valid = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0; rst = 1'b1;
        @(negedge clk); check("rstmid/s1", 32'(s1en), 32'd0);
        check("rstmid/rdy", 32'(instr_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); check("rstmid/s2", 32'(s2en), 32'd0);
        check("rstmid/s1b", 32'(s1en), 32'd0);
        @(posedge clk); #1;

        // HLT, then blocked acceptance, then recovery by reset
        instr_in = 16'h3805; instr_valid = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0;
        @(negedge clk); check("hlt/s1", 32'(s1en), 32'd0);
        check("hlt/halted1", 32'(halted), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); check("hlt/halted2", 32'(halted), 32'd1);
        check("hlt/s2", 32'(s2en), 32'(6'b000001));
        check("hlt/rdy2", 32'(instr_ready), 32'd0);
        @(posedge clk); #1 instr_in = 16'h0000; instr_valid = 1'b1;
        @(negedge clk); check("hlt/halted3", 32'(halted), 32'd1);
        check("hlt/rdy3", 32'(instr_ready), 32'd0);
        check("hlt/s2_3", 32'(s2en), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); check("hlt/noacc", 32'(s1en), 32'd0);
        instr_valid = 1'b0; rst = 1'b1;
        #1 check("hlt/rst_halted", 32'(halted), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); check("hlt/rel_halted", 32'(halted), 32'd0);
        check("hlt/rel_depth", 32'(depth), 32'd0);
        check("hlt/rel_rdy", 32'(instr_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
